// File: rtl/column_sum_controller.sv
// column_sum_controller: walks columns 0..num_cols-1, gating the column-sum datapath
// and handing each captured sum downstream over a valid/ready handshake.
module column_sum_controller #(
    parameter int COL_W      = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [COL_W-1:0] num_cols,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [COL_W-1:0] col_addr,
    output logic             dp_clr,
    input  logic             dp_done,
    input  logic [31:0]      dp_sum,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [COL_W-1:0] res_col
);
    localparam int WD_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT, FINISH} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] n_q, n_d, col_q, col_d, rcol_q, rcol_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [31:0]      data_q, data_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            n_q     <= '0;
            col_q   <= '0;
            rcol_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            col_q   <= col_d;
            rcol_q  <= rcol_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        col_d   = col_q;
        rcol_d  = rcol_q;
        wd_d    = wd_q;
        err_d   = err_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = num_cols;
                    col_d   = '0;
                    err_d   = 1'b0;
                    wd_d    = '0;
                    state_d = (num_cols == '0) ? FINISH : ACCUM;
                end
            end
            ACCUM: begin
                wd_d = wd_q + WD_W'(1);
                // dp_done wins over a watchdog expiring in the same cycle
                if (dp_done) begin
                    data_d  = dp_sum;
                    rcol_d  = col_q;
                    wd_d    = '0;
                    state_d = EMIT;
                end else if (wd_q == WD_W'(WAIT_LIMIT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end
            end
            EMIT: begin
                if (res_ready) begin
                    if (col_q == n_q - COL_W'(1)) begin
                        state_d = FINISH;
                    end else begin
                        col_d   = col_q + COL_W'(1);
                        state_d = ACCUM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign dp_clr    = (state_q != ACCUM);
    assign res_valid = (state_q == EMIT);
    assign err       = err_q;
    assign col_addr  = col_q;
    assign res_data  = data_q;
    assign res_col   = rcol_q;
endmodule

// File: tb/tb_column_sum_controller.sv
// tb_column_sum_controller: scoreboard bench with a 3-term float-summing datapath model.
module tb_column_sum_controller;
    logic        clk = 1'b0;
    logic        clr, start, dp_done, res_ready;
    logic [7:0]  num_cols, col_addr, res_col;
    logic        busy, done, err, dp_clr, res_valid;
    logic [31:0] dp_sum, res_data;

    column_sum_controller #(.COL_W(8), .WAIT_LIMIT(15)) dut (
        .clk(clk), .clr(clr), .start(start), .num_cols(num_cols),
        .busy(busy), .done(done), .err(err), .col_addr(col_addr),
        .dp_clr(dp_clr), .dp_done(dp_done), .dp_sum(dp_sum),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_col(res_col)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  col;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, t0 = 0, rel;
    int          exp_done, stall;
    logic        exp_err, chk_clr, mid_start, stuck;
    logic [31:0] exp_sum [3] = '{32'h40C00000, 32'h40980000, 32'h42700000};

    always @(posedge clk) cyc <= cyc + 1;
    always_comb rel = cyc - t0;

    function automatic logic [31:0] d2f(input real r);
        logic [63:0] b;
        b = $realtobits(r);
        if (r == 0.0) return 32'h0;
        return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
    endfunction

    real        mem [4][3];
    real        acc;
    logic [1:0] cnt;

    always @(posedge clk) begin
        if (dp_clr) begin
            cnt <= 2'd0;
            acc <= 0.0;
        end else if (cnt != 2'd3) begin
            acc <= acc + mem[col_addr[1:0]][cnt];
            cnt <= cnt + 2'd1;
        end
    end
    assign dp_done = (cnt == 2'd3) && !stuck;
    assign dp_sum  = d2f(acc);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (rel cycle %0d)", tag, got, expv, rel);
        end
    endtask

    always @(negedge clk) begin
        if (!clr) begin
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_res", {31'b0, res_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("res_col", {24'b0, res_col}, {24'b0, e.col});
                    chk("res_data", res_data, e.data);
                    chk("res_cycle", rel, e.at);
                end
            end
            if (done) begin
                chk("done_cycle", rel, exp_done);
                chk("left_in_queue", q.size(), 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input int n);
        start    = 1'b1;
        num_cols = 8'(n);
        t0       = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic run(input int limit);
        for (int i = 0; i < limit; i++) begin
            res_ready = !(rel >= 5 && rel < 5 + stall);
            start     = mid_start && (rel == 3 || rel == 7 || rel == 10);
            if (chk_clr)
                chk("dp_clr", {31'b0, dp_clr},
                    {31'b0, !((rel >= 1 && rel <= 4) || (rel >= 6 && rel <= 9) || (rel >= 11 && rel <= 14))});
            if (stall > 0 && rel >= 5 && rel < 5 + stall) begin
                chk("stall_valid", {31'b0, res_valid}, 32'd1);
                chk("stall_data", res_data, exp_sum[0]);
                chk("stall_col", {24'b0, res_col}, 32'd0);
                chk("stall_dp_clr", {31'b0, dp_clr}, 32'd1);
            end
            if (stuck && rel == 15) chk("wd_err_early", {31'b0, err}, 32'd0);
            if (stuck && rel == 16) chk("wd_err", {31'b0, err}, 32'd1);
            if (!busy) break;
            tick();
        end
        res_ready = 1'b1;
        start     = 1'b0;
        chk("busy_end", {31'b0, busy}, 32'd0);
        chk("idle_cycle", rel, exp_done + 1);
        chk("err_end", {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic go(input int n, input int st);
        stall    = st;
        exp_done = 5 * n + 1 + st;
        for (int c = 0; c < n; c++) q.push_back('{8'(c), exp_sum[c], 5 * (c + 1) + st});
        start_pass(n);
        run(5 * n + st + 10);
    endtask

    initial begin
        mem[0] = '{1.0, 2.0, 3.0};
        mem[1] = '{0.5, 0.25, 4.0};
        mem[2] = '{10.0, 20.0, 30.0};
        mem[3] = '{0.0, 0.0, 0.0};
        clr = 1'b1; start = 1'b0; num_cols = 8'd0; res_ready = 1'b1; stuck = 1'b0;
        stall = 0; chk_clr = 1'b0; mid_start = 1'b0; exp_done = -1; exp_err = 1'b0;
        repeat (3) tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_col_addr", {24'b0, col_addr}, 32'd0);
        chk("rst_dp_clr", {31'b0, dp_clr}, 32'd1);
        chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
        chk("rst_res_data", res_data, 32'd0);
        chk("rst_res_col", {24'b0, res_col}, 32'd0);
        clr = 1'b0;
        tick();

        go(1, 0);
        chk_clr = 1'b1;
        go(3, 0);
        chk_clr = 1'b0;
        go(2, 3);

        exp_done = 1;
        stall    = 0;
        start_pass(0);
        chk("busy_zero", {31'b0, busy}, 32'd1);
        run(10);

        mid_start = 1'b1;
        num_cols  = 8'd3;
        exp_done  = 11;
        q.push_back('{8'd0, exp_sum[0], 5});
        q.push_back('{8'd1, exp_sum[1], 10});
        start_pass(2);
        num_cols = 8'd3;
        run(20);
        mid_start = 1'b0;

        stuck    = 1'b1;
        exp_done = 16;
        exp_err  = 1'b1;
        start_pass(3);
        run(30);
        stuck   = 1'b0;
        exp_err = 1'b0;
        exp_done = 6;
        q.push_back('{8'd0, exp_sum[0], 5});
        start_pass(1);
        chk("err_cleared", {31'b0, err}, 32'd0);
        run(12);

        exp_done = -1;
        q.push_back('{8'd0, exp_sum[0], 5});
        start_pass(3);
        repeat (6) tick();
        chk("mid_col_addr", {24'b0, col_addr}, 32'd1);
        chk("mid_dp_clr", {31'b0, dp_clr}, 32'd0);
        clr = 1'b1;
        tick();
        chk("clr_busy", {31'b0, busy}, 32'd0);
        chk("clr_res_valid", {31'b0, res_valid}, 32'd0);
        chk("clr_col_addr", {24'b0, col_addr}, 32'd0);
        chk("clr_dp_clr", {31'b0, dp_clr}, 32'd1);
        chk("clr_done", {31'b0, done}, 32'd0);
        chk("clr_res_data", res_data, 32'd0);
        chk("clr_queue", q.size(), 0);
        clr = 1'b0;
        tick();
        go(3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
